uart_rx: RTL and testbench

//  UART receiver, 8N1 by default. Paced by the 16x oversampling tick from the baud timer (s_tick, one clk wide).

---
 rtl/uart_rx.sv | 161 ++++++++++++++++
 tb/tb_uart_rx.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver paced by a 16x oversampling tick; optional parity via UART_RX_PARITY_EN
module uart_rx #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int OS      = 16
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PAR_ODD = 1'b0
`endif
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            s_tick,
  input  logic            rx,
  input  logic            rx_rd,
  output logic [DBIT-1:0] rx_data,
  output logic            rx_valid,
  output logic            rx_done,
  output logic            frame_err,
  output logic            ovr_err,
`ifdef UART_RX_PARITY_EN
  output logic            par_err,
`endif
  output logic            busy
);
  localparam int TW = $clog2(OS * 2);
  localparam int BW = $clog2(DBIT + 1);
  localparam logic [TW-1:0] HALF    = TW'(OS / 2 - 1);
  localparam logic [TW-1:0] FULL    = TW'(OS - 1);
  localparam logic [TW-1:0] SB_LAST = TW'(SB_TICK - 1);
  localparam logic [BW-1:0] B_LAST  = BW'(DBIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t          state, state_n;
  logic [TW-1:0]   tick_cnt, tick_n;
  logic [BW-1:0]   bit_cnt, bit_n;
  logic [DBIT-1:0] shreg, shreg_n;
  logic            rx_meta, rx_s;
  logic            done_n;
`ifdef UART_RX_PARITY_EN
  logic            par_bit, par_n;
`endif

  assign busy = (state != IDLE);

  // two-flop synchronizer; preset high so reset never looks like a start edge
  always_ff @(posedge clk or posedge reset)
    if (reset) {rx_s, rx_meta} <= 2'b11;
    else {rx_s, rx_meta} <= {rx_meta, rx};

  // FSM and datapath state registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef UART_RX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shreg    <= shreg_n;
`ifdef UART_RX_PARITY_EN
      par_bit  <= par_n;
`endif
    end

  // next-state: edge check every clk in IDLE, everything else advances only on s_tick
  always_comb begin
    state_n = state;
    tick_n  = tick_cnt;
    bit_n   = bit_cnt;
    shreg_n = shreg;
    done_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_n   = par_bit;
`endif
    case (state)
      IDLE:
        if (!rx_s) begin
          state_n = START;
          tick_n  = '0;
        end
      START:
        if (s_tick) begin
          if (tick_cnt == HALF) begin
            tick_n  = '0;
            bit_n   = '0;
            state_n = rx_s ? IDLE : DATA;
          end else tick_n = tick_cnt + 1'b1;
        end
      DATA:
        if (s_tick) begin
          if (tick_cnt == FULL) begin
            tick_n  = '0;
            shreg_n = {rx_s, shreg[DBIT-1:1]};
            bit_n   = bit_cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_cnt == B_LAST) state_n = PARITY;
`else
            if (bit_cnt == B_LAST) state_n = STOP;
`endif
          end else tick_n = tick_cnt + 1'b1;
        end
`ifdef UART_RX_PARITY_EN
      PARITY:
        if (s_tick) begin
          if (tick_cnt == FULL) begin
            tick_n  = '0;
            par_n   = rx_s;
            state_n = STOP;
          end else tick_n = tick_cnt + 1'b1;
        end
`endif
      STOP:
        if (s_tick) begin
          if (tick_cnt == SB_LAST) begin
            tick_n  = '0;
            state_n = IDLE;
            done_n  = 1'b1;
          end else tick_n = tick_cnt + 1'b1;
        end
      default: state_n = IDLE;
    endcase
  end

  // host side: completion beats a simultaneous read, but that read still counts as draining the old byte
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_done   <= 1'b0;
      frame_err <= 1'b0;
      ovr_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      rx_done <= done_n;
      if (done_n) begin
        rx_data   <= shreg;
        rx_valid  <= 1'b1;
        frame_err <= (frame_err & ~rx_rd) | ~rx_s;
        ovr_err   <= (ovr_err | rx_valid) & ~rx_rd;
`ifdef UART_RX_PARITY_EN
        par_err   <= (par_err & ~rx_rd) | (^shreg ^ par_bit ^ PAR_ODD);
`endif
      end else if (rx_rd) begin
        rx_valid  <= 1'b0;
        frame_err <= 1'b0;
        ovr_err   <= 1'b0;
`ifdef UART_RX_PARITY_EN
        par_err   <= 1'b0;
`endif
      end
    end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed self-checking bench for uart_rx (16x tick, 8 data bits)
module tb_uart_rx;
`ifdef UART_RX_PARITY_EN
  localparam int P = 1;
  logic par_err;
`else
  localparam int P = 0;
`endif
  localparam int FB = 10 + P;
  localparam int DONE_T = 16 * (FB - 1) + 9;

  logic clk = 1'b0, reset = 1'b1, s_tick = 1'b0, rx = 1'b1, rx_rd = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, rx_done, frame_err, ovr_err, busy;
  int n_cmp = 0, n_bad = 0, done_cnt = 0;

  uart_rx dut (
    .clk(clk), .reset(reset), .s_tick(s_tick), .rx(rx), .rx_rd(rx_rd),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_done(rx_done),
    .frame_err(frame_err), .ovr_err(ovr_err),
`ifdef UART_RX_PARITY_EN
    .par_err(par_err),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (rx_done) done_cnt <= done_cnt + 1;

  task automatic tick(input logic rd);
    @(negedge clk); s_tick = 1'b1; rx_rd = rd;
    @(negedge clk); s_tick = 1'b0; rx_rd = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0);
  endtask

  task automatic read();
    @(negedge clk); rx_rd = 1'b1;
    @(negedge clk); rx_rd = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic stop_ok, input logic par, input int rd_t, input int abort_t);
    logic [11:0] fr;
    int b;
    fr = '1;
    fr[0] = 1'b0;
    fr[8:1] = d;
    if (P == 1) fr[9] = par;
    for (int t = 1; t <= 16 * FB; t++) begin
      b = (t - 1) / 16;
      rx = (b == FB - 1) ? (stop_ok || t > 16 * (FB - 1) + 10) : fr[b];
      if (t == abort_t) begin
        reset = 1'b1;
        return;
      end
      tick(t == rd_t);
    end
    rx = 1'b1;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", rx_data); end
    n_cmp++; if ({rx_done, frame_err, ovr_err} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {rx_done, frame_err, ovr_err}); end
    reset = 1'b0;
    idle(2);
  endtask

  task automatic test_good();
    int d0 = done_cnt;
    send(8'hA5, 1'b1, 1'b0, 0, 0);
    idle(2);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL good_done: got %0d pulses want 1", done_cnt - d0); end
    n_cmp++; if (rx_data !== 8'hA5) begin n_bad++; $display("FAIL good_data: got %h want a5", rx_data); end
    n_cmp++; if (rx_valid !== 1'b1) begin n_bad++; $display("FAIL good_valid: got %b want 1", rx_valid); end
    n_cmp++; if ({frame_err, ovr_err} !== 2'b00) begin n_bad++; $display("FAIL good_flags: got %b want 00", {frame_err, ovr_err}); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL good_busy: got %b want 0", busy); end
    read();
    n_cmp++; if (rx_valid !== 1'b0) begin n_bad++; $display("FAIL good_read: got %b want 0", rx_valid); end
  endtask

  task automatic test_frame_err();
    int d0 = done_cnt;
    send(8'h3C, 1'b0, 1'b0, 0, 0);
    idle(4);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL ferr_done: got %0d pulses want 1", done_cnt - d0); end
    n_cmp++; if (rx_data !== 8'h3C) begin n_bad++; $display("FAIL ferr_data: got %h want 3c", rx_data); end
    n_cmp++; if ({rx_valid, frame_err} !== 2'b11) begin n_bad++; $display("FAIL ferr_flags: got %b want 11", {rx_valid, frame_err}); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL ferr_idle: got %b want 0", busy); end
    read();
    n_cmp++; if ({rx_valid, frame_err} !== 2'b00) begin n_bad++; $display("FAIL ferr_read: got %b want 00", {rx_valid, frame_err}); end
  endtask

  task automatic test_glitch();
    int d0 = done_cnt;
    rx = 1'b0;
    idle(4);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL glitch_start: got busy %b want 1", busy); end
    rx = 1'b1;
    idle(10);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL glitch_idle: got busy %b want 0", busy); end
    n_cmp++; if (done_cnt !== d0) begin n_bad++; $display("FAIL glitch_done: got %0d pulses want 0", done_cnt - d0); end
    n_cmp++; if ({rx_valid, frame_err} !== 2'b00) begin n_bad++; $display("FAIL glitch_flags: got %b want 00", {rx_valid, frame_err}); end
  endtask

  task automatic test_overrun();
    int d0 = done_cnt;
    send(8'h11, 1'b1, 1'b0, 0, 0);
    send(8'h22, 1'b1, 1'b0, 0, 0);
    idle(2);
    n_cmp++; if (done_cnt - d0 !== 2) begin n_bad++; $display("FAIL b2b_done: got %0d pulses want 2", done_cnt - d0); end
    n_cmp++; if (rx_data !== 8'h22) begin n_bad++; $display("FAIL b2b_data: got %h want 22", rx_data); end
    n_cmp++; if ({rx_valid, ovr_err, frame_err} !== 3'b110) begin n_bad++; $display("FAIL b2b_flags: got %b want 110", {rx_valid, ovr_err, frame_err}); end
    d0 = done_cnt;
    send(8'h33, 1'b1, 1'b0, DONE_T, 0);
    idle(2);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL rdwin_done: got %0d pulses want 1", done_cnt - d0); end
    n_cmp++; if (rx_data !== 8'h33) begin n_bad++; $display("FAIL rdwin_data: got %h want 33", rx_data); end
    n_cmp++; if ({rx_valid, ovr_err, frame_err} !== 3'b100) begin n_bad++; $display("FAIL rdwin_flags: got %b want 100", {rx_valid, ovr_err, frame_err}); end
  endtask

  task automatic test_reset_mid();
    int d0 = done_cnt;
    send(8'hFF, 1'b1, 1'b0, 0, 16 * 5 + 8);
    #1;
    n_cmp++; if ({busy, rx_valid} !== 2'b00) begin n_bad++; $display("FAIL rmid_state: got %b want 00", {busy, rx_valid}); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL rmid_data: got %h want 00", rx_data); end
    @(negedge clk); reset = 1'b0; rx = 1'b1;
    idle(4);
    n_cmp++; if (done_cnt !== d0) begin n_bad++; $display("FAIL rmid_done: got %0d pulses want 0", done_cnt - d0); end
    send(8'h5A, 1'b1, 1'b0, 0, 0);
    idle(2);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL rmid_next_done: got %0d pulses want 1", done_cnt - d0); end
    n_cmp++; if (rx_data !== 8'h5A) begin n_bad++; $display("FAIL rmid_next_data: got %h want 5a", rx_data); end
    n_cmp++; if ({rx_valid, ovr_err, frame_err} !== 3'b100) begin n_bad++; $display("FAIL rmid_next_flags: got %b want 100", {rx_valid, ovr_err, frame_err}); end
    read();
  endtask

  task automatic test_break();
    int d0 = done_cnt;
    rx = 1'b0;
    idle(156);
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL brk_done: got %0d pulses want 1", done_cnt - d0); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL brk_restart: got busy %b want 1", busy); end
    rx = 1'b1;
    idle(10);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL brk_idle: got busy %b want 0", busy); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL brk_data: got %h want 00", rx_data); end
    n_cmp++; if ({rx_valid, frame_err, ovr_err} !== 3'b110) begin n_bad++; $display("FAIL brk_flags: got %b want 110", {rx_valid, frame_err, ovr_err}); end
    n_cmp++; if (done_cnt - d0 !== 1) begin n_bad++; $display("FAIL brk_once: got %0d pulses want 1", done_cnt - d0); end
    read();
  endtask

  task automatic test_rd_noop();
    read();
    n_cmp++; if ({rx_valid, frame_err, ovr_err} !== 3'b000) begin n_bad++; $display("FAIL noop_flags: got %b want 000", {rx_valid, frame_err, ovr_err}); end
    n_cmp++; if (rx_data !== 8'h00) begin n_bad++; $display("FAIL noop_data: got %h want 00", rx_data); end
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send(8'h07, 1'b1, 1'b1, 0, 0);
    idle(2);
    n_cmp++; if ({rx_valid, par_err} !== 2'b10) begin n_bad++; $display("FAIL par_good: got %b want 10", {rx_valid, par_err}); end
    read();
    send(8'h07, 1'b1, 1'b0, 0, 0);
    idle(2);
    n_cmp++; if ({rx_valid, par_err, frame_err} !== 3'b110) begin n_bad++; $display("FAIL par_bad: got %b want 110", {rx_valid, par_err, frame_err}); end
    read();
    n_cmp++; if (par_err !== 1'b0) begin n_bad++; $display("FAIL par_clear: got %b want 0", par_err); end
  endtask
`endif

  initial begin
    test_reset();
    test_good();
    test_frame_err();
    test_glitch();
    test_overrun();
    test_reset_mid();
    test_break();
    test_rd_noop();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
